ram_port_arbiter: RTL



---
 rtl/ram_port_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port between ioctl download, CPU
// and video fetch, with an optional zero-fill of the whole RAM after reset.
module ram_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              we2,
  output logic              ack2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_enable,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic [1:0] GNT_IOCTL = 2'd0;
  localparam logic [1:0] GNT_CPU   = 2'd1;
  localparam logic [1:0] GNT_VIDEO = 2'd2;

  localparam logic [1:0] ST_RESET   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic       BUSY_RESET = (CLEAR_ON_RESET != 0);

  logic [1:0]        state_r;
  logic [1:0]        gnt_r;
  logic              gnt_we_r;
  logic [1:0]        last_rr_r;
  logic [ADDR_W:0]   clr_cnt_r;
  logic              busy_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_data_r;
  logic              ram_wren_r;
  logic              ram_enable_r;
  logic [2:0]        ack_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic [DATA_W-1:0] rdata2_r;

  logic [2:0]        elig_s;
  logic              grant_valid_s;
  logic              rr_update_s;
  logic [1:0]        grant_idx_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;

  // Grant selection: ioctl first, then round-robin CPU/video; acked requesters are masked.
  always_comb begin
    elig_s        = {req2 & ~ack_r[2], req1 & ~ack_r[1], req0 & ~ack_r[0]};
    grant_valid_s = 1'b0;
    grant_idx_s   = GNT_IOCTL;
    rr_update_s   = 1'b0;
    if (elig_s[0]) begin
      grant_valid_s = 1'b1;
      grant_idx_s   = GNT_IOCTL;
    end else if (elig_s[1] && elig_s[2]) begin
      grant_valid_s = 1'b1;
      rr_update_s   = 1'b1;
      grant_idx_s   = (last_rr_r == GNT_CPU) ? GNT_VIDEO : GNT_CPU;
    end else if (elig_s[1]) begin
      grant_valid_s = 1'b1;
      grant_idx_s   = GNT_CPU;
    end else if (elig_s[2]) begin
      grant_valid_s = 1'b1;
      grant_idx_s   = GNT_VIDEO;
    end else begin
      grant_valid_s = 1'b0;
      grant_idx_s   = GNT_IOCTL;
    end
  end

  // Request fields of the requester being granted.
  always_comb begin
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    sel_we_s    = we0;
    case (grant_idx_s)
      GNT_CPU: begin
        sel_addr_s  = addr1;
        sel_wdata_s = wdata1;
        sel_we_s    = we1;
      end
      GNT_VIDEO: begin
        sel_addr_s  = addr2;
        sel_wdata_s = wdata2;
        sel_we_s    = we2;
      end
      default: begin
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        sel_we_s    = we0;
      end
    endcase
  end

  // Port sequencer: clear sweep, then grant -> issue -> wait -> ack per access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_RESET;
      gnt_r        <= GNT_IOCTL;
      gnt_we_r     <= 1'b0;
      last_rr_r    <= GNT_VIDEO;
      clr_cnt_r    <= {(ADDR_W+1){1'b0}};
      busy_r       <= BUSY_RESET;
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_data_r   <= {DATA_W{1'b0}};
      ram_wren_r   <= 1'b0;
      ram_enable_r <= 1'b0;
      ack_r        <= 3'b000;
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
      rdata2_r     <= {DATA_W{1'b0}};
    end else begin
      ack_r <= 3'b000;
      case (state_r)
        ST_CLEAR: begin
          // The counter's extra top bit marks that the last address was written.
          if (clr_cnt_r[ADDR_W]) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            ram_wren_r   <= 1'b0;
            ram_enable_r <= 1'b0;
          end else begin
            ram_addr_r   <= clr_cnt_r[ADDR_W-1:0];
            ram_data_r   <= {DATA_W{1'b0}};
            ram_wren_r   <= 1'b1;
            ram_enable_r <= 1'b1;
            clr_cnt_r    <= clr_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (grant_valid_s) begin
            ram_addr_r   <= sel_addr_s;
            ram_data_r   <= sel_wdata_s;
            ram_wren_r   <= sel_we_s;
            ram_enable_r <= 1'b1;
            gnt_r        <= grant_idx_s;
            gnt_we_r     <= sel_we_s;
            state_r      <= ST_ISSUE;
            if (rr_update_s) begin
              last_rr_r <= grant_idx_s;
            end
          end else begin
            ram_wren_r   <= 1'b0;
            ram_enable_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          ram_wren_r   <= 1'b0;
          ram_enable_r <= 1'b0;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          state_r <= ST_IDLE;
          case (gnt_r)
            GNT_IOCTL: begin
              ack_r <= 3'b001;
              if (!gnt_we_r) begin
                rdata0_r <= ram_q;
              end
            end
            GNT_CPU: begin
              ack_r <= 3'b010;
              if (!gnt_we_r) begin
                rdata1_r <= ram_q;
              end
            end
            GNT_VIDEO: begin
              ack_r <= 3'b100;
              if (!gnt_we_r) begin
                rdata2_r <= ram_q;
              end
            end
            default: begin
              ack_r <= 3'b000;
            end
          endcase
        end
        default: begin
          state_r      <= ST_IDLE;
          ram_wren_r   <= 1'b0;
          ram_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign ack0       = ack_r[0];
  assign ack1       = ack_r[1];
  assign ack2       = ack_r[2];
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;
  assign rdata2     = rdata2_r;
  assign busy       = busy_r;
  assign ram_addr   = ram_addr_r;
  assign ram_data   = ram_data_r;
  assign ram_wren   = ram_wren_r;
  assign ram_enable = ram_enable_r;

endmodule
